ip_perm_pipe: RTL and testbench

Registered, parametrised successor to the combinational 128-bit initial-permutation stage of the expanded-DES datapath. Applies the DES-style bit permutation independently to each of `LANES` 64-bit lanes, in forward (IP) or, optionally, inverse (IP⁻¹ / final permutation) mode chosen per transaction. Sits between the block-input register and the round pipeline, or, in inverse mode, after the last round. A valid/ready handshake with a 2-entry skid buffer gives full throughput under backpressure.

---
 rtl/ip_pkg.sv | 21 ++
 rtl/ip_lane_perm.sv | 47 ++++
 rtl/ip_perm_pipe.sv | 106 ++++++++++
 tb/tb_ip_perm_pipe.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_pkg.sv
// ip_pkg: shared constants and types for the DES-style initial-permutation pipe.
// Contents: lane width, the row-offset table S, lane-word and occupancy types.
// Optional feature macro used by consumers: IP_PERM_INV_EN (inverse mapping).
package ip_pkg;

   localparam int unsigned IP_LANE_W = 64;
   localparam int unsigned IP_ROWS   = 8;

   // Source-bit base offsets per output column: out[63-8r-c] = in[r + IP_S[c]]
   localparam int unsigned IP_S [IP_ROWS] = '{24, 56, 16, 48, 8, 40, 0, 32};

   typedef logic [IP_LANE_W-1:0] lane_t;

   // Occupancy of the output/skid pair; value equals the Count port
   typedef enum logic [1:0] {
      CNT_EMPTY = 2'd0,
      CNT_ONE   = 2'd1,
      CNT_FULL  = 2'd2
   } cnt_e;

endpackage

// File: rtl/ip_lane_perm.sv
// ip_lane_perm: combinational DES initial permutation of one 64-bit lane.
// Ports:
//   Data  in  64  lane word
//   Inv   in  1   0 forward (IP), 1 inverse (IP^-1); ignored unless IP_PERM_INV_EN
//   Perm  out 64  permuted lane word
// Macro: IP_PERM_INV_EN compiles the inverse branch; otherwise always forward.
module ip_lane_perm
   import ip_pkg::*;
(
   input  logic [IP_LANE_W-1:0] Data,
   input  logic                 Inv,
   output logic [IP_LANE_W-1:0] Perm
);

   lane_t fwd_c;

   // Forward map
   always_comb begin
      fwd_c = '0;
      for (int unsigned r = 0; r < IP_ROWS; r++) begin
         for (int unsigned c = 0; c < IP_ROWS; c++) begin
            fwd_c[6'(63 - 8*r - c)] = Data[6'(r + IP_S[3'(c)])];
         end
      end
   end

`ifdef IP_PERM_INV_EN
   lane_t inv_c;

   // Inverse map: same wiring with source and destination swapped
   always_comb begin
      inv_c = '0;
      for (int unsigned r = 0; r < IP_ROWS; r++) begin
         for (int unsigned c = 0; c < IP_ROWS; c++) begin
            inv_c[6'(r + IP_S[3'(c)])] = Data[6'(63 - 8*r - c)];
         end
      end
   end

   assign Perm = Inv ? inv_c : fwd_c;
`else
   logic unused_inv;
   assign unused_inv = Inv;
   assign Perm       = fwd_c;
`endif

endmodule

// File: rtl/ip_perm_pipe.sv
// ip_perm_pipe: registered LANES x 64-bit DES initial permutation with a
// valid/ready handshake and a 2-entry skid buffer (output reg + skid reg).
// Ports:
//   Clk        in  1   rising-edge clock
//   Reset      in  1   synchronous active-high reset
//   In         in  W   input block, W = 64*LANES
//   In_Inv     in  1   per-transaction mode, 0 forward / 1 inverse
//   In_Valid   in  1   In/In_Inv valid
//   In_Ready   out 1   can accept (registered)
//   Cipertext  out W   permuted block
//   Out_Valid  out 1   Cipertext valid
//   Out_Ready  in  1   downstream accepts
//   Count      out 2   entries held, 0..2
// Macro: IP_PERM_INV_EN enables inverse mode; undefined => forward only.
module ip_perm_pipe
   import ip_pkg::*;
#(
   parameter  int unsigned LANES = 2,
   localparam int unsigned W     = LANES * IP_LANE_W
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic [W-1:0] In,
   input  logic         In_Inv,
   input  logic         In_Valid,
   output logic         In_Ready,
   output logic [W-1:0] Cipertext,
   output logic         Out_Valid,
   input  logic         Out_Ready,
   output logic [1:0]   Count
);

   logic [W-1:0] perm_c;
   logic [W-1:0] cipher_q;
   logic [W-1:0] skid_q;
   logic         in_ready_q;
   logic         out_valid_q;
   cnt_e         state_q;
   logic         accept_c;
   logic         xfer_c;

   // Per-lane permutation; no bit crosses a lane boundary
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      ip_lane_perm u_perm (
         .Data (In[k*IP_LANE_W +: IP_LANE_W]),
         .Inv  (In_Inv),
         .Perm (perm_c[k*IP_LANE_W +: IP_LANE_W])
      );
   end

   assign accept_c = In_Valid && in_ready_q;
   assign xfer_c   = out_valid_q && Out_Ready;

   // Occupancy FSM; entries store already-permuted words so the tag is dropped
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= CNT_EMPTY;
         cipher_q    <= '0;
         skid_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            CNT_EMPTY: begin
               if (accept_c) begin
                  cipher_q    <= perm_c;
                  out_valid_q <= 1'b1;
                  state_q     <= CNT_ONE;
               end
            end
            CNT_ONE: begin
               if (accept_c && !xfer_c) begin
                  skid_q     <= perm_c;
                  in_ready_q <= 1'b0;
                  state_q    <= CNT_FULL;
               end else if (!accept_c && xfer_c) begin
                  out_valid_q <= 1'b0;
                  state_q     <= CNT_EMPTY;
               end else if (accept_c && xfer_c) begin
                  // Pass-through: new word replaces the one leaving
                  cipher_q <= perm_c;
               end
            end
            CNT_FULL: begin
               // In_Ready is low here, so only a transfer can happen
               if (xfer_c) begin
                  cipher_q   <= skid_q;
                  in_ready_q <= 1'b1;
                  state_q    <= CNT_ONE;
               end
            end
            default: begin
               state_q     <= CNT_EMPTY;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign In_Ready  = in_ready_q;
   assign Out_Valid = out_valid_q;
   assign Cipertext = cipher_q;
   assign Count     = state_q;

endmodule

// File: tb/tb_ip_perm_pipe.sv
// tb_ip_perm_pipe: directed self-checking bench for ip_perm_pipe
// (LANES=2 main instance, LANES=4 secondary instance).
module tb_ip_perm_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset;
   logic [127:0] in_d;
   logic         in_inv;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] ciph;
   logic         out_valid;
   logic         out_ready;
   logic [1:0]   count;

   logic [255:0] in4_d;
   logic         in4_valid;
   logic         in4_ready;
   logic [255:0] ciph4;
   logic         out4_valid;
   logic         out4_ready;
   logic [1:0]   count4;

   int checks   = 0;
   int failures = 0;

   int s_tab [8] = '{24, 56, 16, 48, 8, 40, 0, 32};

   ip_perm_pipe #(.LANES(2)) u_dut (
      .Clk(clk), .Reset(reset), .In(in_d), .In_Inv(in_inv), .In_Valid(in_valid),
      .In_Ready(in_ready), .Cipertext(ciph), .Out_Valid(out_valid),
      .Out_Ready(out_ready), .Count(count)
   );

   ip_perm_pipe #(.LANES(4)) u_dut4 (
      .Clk(clk), .Reset(reset), .In(in4_d), .In_Inv(1'b0), .In_Valid(in4_valid),
      .In_Ready(in4_ready), .Cipertext(ciph4), .Out_Valid(out4_valid),
      .Out_Ready(out4_ready), .Count(count4)
   );

   // Reference model, walked from the source side: bit i = r + base lands at 63-8r-c
   function automatic logic [63:0] fwd_model(input logic [63:0] x);
      logic [63:0] y;
      int r;
      int base;
      y = '0;
      for (int i = 0; i < 64; i++) begin
         r    = i % 8;
         base = i - r;
         for (int c = 0; c < 8; c++)
            if (s_tab[c] == base) y[63 - 8*r - c] = x[i];
      end
      return y;
   endfunction

   function automatic logic [127:0] vec(input int i);
      logic [63:0] hi;
      logic [63:0] lo;
      hi = 64'(i) * 64'h9E37_79B9_7F4A_7C15;
      lo = ~64'(i);
      return {hi, lo};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b1; in_d = 128'hDEAD_BEEF; out_ready = 1'b0;
      in4_valid = 1'b1; in4_d = '1; out4_ready = 1'b0;
      step(); step();
      checks += 5;
      if (ciph !== 128'h0) begin failures++; $display("FAIL reset_cipher: got %h want 0", ciph); end
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      if (count !== 2'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", count); end
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      if (count4 !== 2'd0 || out4_valid !== 1'b0) begin
         failures++; $display("FAIL reset_dut4: got count=%0d valid=%b want 0/0", count4, out4_valid);
      end
      reset = 1'b0; in_valid = 1'b0; in4_valid = 1'b0;
   endtask

   task automatic test_single_bit();
      out_ready = 1'b1; in_inv = 1'b0;
      in_valid = 1'b1; in_d = 128'h1;
      step();
      checks += 2;
      if (ciph !== 128'h0200_0000_0000_0000) begin
         failures++; $display("FAIL single_bit0: got %h want %h", ciph, 128'h0200_0000_0000_0000);
      end
      if (out_valid !== 1'b1 || count !== 2'd1) begin
         failures++; $display("FAIL single_bit0_state: got valid=%b count=%0d want 1/1", out_valid, count);
      end
      in_d = 128'h1 << 64;
      step();
      checks++;
      if (ciph !== (128'h1 << 121)) begin
         failures++; $display("FAIL single_bit64: got %h want %h", ciph, 128'h1 << 121);
      end
      in_valid = 1'b0;
      step();
      checks += 2;
      if (out_valid !== 1'b0 || count !== 2'd0) begin
         failures++; $display("FAIL drain_state: got valid=%b count=%0d want 0/0", out_valid, count);
      end
      if (ciph !== (128'h1 << 121)) begin
         failures++; $display("FAIL hold_after_empty: got %h want %h", ciph, 128'h1 << 121);
      end
   endtask

   task automatic test_mode_tag();
      logic [127:0] exp;
      out_ready = 1'b1; in_valid = 1'b1; in_inv = 1'b1;
      in_d = 128'h0200_0000_0000_0000;
`ifdef IP_PERM_INV_EN
      exp = 128'h1;
`else
      exp = 128'h0040_0000_0000_0000;
`endif
      step();
      checks++;
      if (ciph !== exp) begin failures++; $display("FAIL mode_tag: got %h want %h", ciph, exp); end
      in_valid = 1'b0; in_inv = 1'b0;
      step();
   endtask

`ifdef IP_PERM_INV_EN
   task automatic test_roundtrip();
      logic [127:0] x;
      logic [127:0] y;
      int bad;
      bad = 0;
      out_ready = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         x = {$urandom, $urandom, $urandom, $urandom};
         in_valid = 1'b1; in_inv = 1'b0; in_d = x;
         step();
         y = ciph;
         in_inv = 1'b1; in_d = y;
         step();
         checks++;
         if (ciph !== x) begin
            failures++;
            if (bad < 5) $display("FAIL roundtrip[%0d]: got %h want %h", n, ciph, x);
            bad++;
         end
      end
      in_valid = 1'b0; in_inv = 1'b0;
      step();
   endtask
`endif

   task automatic test_backpressure();
      localparam logic [127:0] A  = 128'h1;
      localparam logic [127:0] B  = 128'h1 << 64;
      localparam logic [127:0] C  = (128'h1 << 64) | 128'h1;
      localparam logic [127:0] FA = 128'h0200_0000_0000_0000;
      localparam logic [127:0] FB = 128'h1 << 121;
      localparam logic [127:0] FC = (128'h1 << 121) | (128'h1 << 57);
      out_ready = 1'b0; in_inv = 1'b0;
      in_valid = 1'b1; in_d = A;
      step();
      in_d = B;
      step();
      checks += 2;
      if (count !== 2'd2 || in_ready !== 1'b0) begin
         failures++; $display("FAIL bp_full: got count=%0d in_ready=%b want 2/0", count, in_ready);
      end
      if (ciph !== FA) begin failures++; $display("FAIL bp_head: got %h want %h", ciph, FA); end
      in_d = C;
      step();
      checks++;
      if (count !== 2'd2 || ciph !== FA || out_valid !== 1'b1) begin
         failures++; $display("FAIL bp_stall: got count=%0d cipher=%h want 2/%h", count, ciph, FA);
      end
      out_ready = 1'b1;
      step();
      checks++;
      if (ciph !== FB || count !== 2'd1 || in_ready !== 1'b1) begin
         failures++; $display("FAIL bp_out_b: got cipher=%h count=%0d want %h/1", ciph, count, FB);
      end
      step();
      checks++;
      if (ciph !== FC || count !== 2'd1) begin
         failures++; $display("FAIL bp_out_c: got cipher=%h count=%0d want %h/1", ciph, count, FC);
      end
      in_valid = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b0 || count !== 2'd0) begin
         failures++; $display("FAIL bp_drain: got valid=%b count=%0d want 0/0", out_valid, count);
      end
   endtask

   task automatic test_streaming();
      logic [127:0] x;
      logic [127:0] exp;
      int n_out;
      int bad;
      n_out = 0; bad = 0;
      out_ready = 1'b1; in_inv = 1'b0; in_valid = 1'b1; in_d = vec(0);
      for (int i = 0; i < 100; i++) begin
         step();
         x   = vec(i);
         exp = {fwd_model(x[127:64]), fwd_model(x[63:0])};
         if (out_valid === 1'b1) n_out++;
         checks++;
         if (ciph !== exp || count !== 2'd1 || out_valid !== 1'b1) begin
            failures++;
            if (bad < 5) $display("FAIL stream[%0d]: got %h count=%0d want %h count=1", i, ciph, count, exp);
            bad++;
         end
         if (i < 99) in_d = vec(i + 1);
         else in_valid = 1'b0;
      end
      step();
      checks += 2;
      if (n_out !== 100) begin failures++; $display("FAIL stream_count: got %0d want 100", n_out); end
      if (count !== 2'd0) begin failures++; $display("FAIL stream_drain: got %0d want 0", count); end
   endtask

   task automatic test_reset_mid();
      int seen;
      seen = 0;
      out_ready = 1'b0; in_inv = 1'b0; in_valid = 1'b1;
      in_d = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
      step();
      in_d = 128'hFFFF_0000_FFFF_0000_AAAA_5555_AAAA_5555;
      step();
      checks++;
      if (count !== 2'd2) begin failures++; $display("FAIL rst_mid_fill: got %0d want 2", count); end
      reset = 1'b1; in_d = 128'h77;
      step();
      checks += 4;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
      if (ciph !== 128'h0) begin failures++; $display("FAIL rst_mid_cipher: got %h want 0", ciph); end
      if (count !== 2'd0) begin failures++; $display("FAIL rst_mid_count: got %0d want 0", count); end
      if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); end
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         if (out_valid !== 1'b0) seen++;
      end
      checks++;
      if (seen !== 0) begin failures++; $display("FAIL rst_mid_ghost: got %0d valid cycles want 0", seen); end
   endtask

   task automatic test_lanes4();
      logic [63:0] lane [4];
      logic [63:0] got;
      logic [63:0] exp;
      out4_ready = 1'b1;
      for (int v = 0; v < 4; v++) begin
         for (int k = 0; k < 4; k++) begin
            lane[k] = {$urandom, $urandom};
            in4_d[k*64 +: 64] = lane[k];
         end
         in4_valid = 1'b1;
         step();
         for (int k = 0; k < 4; k++) begin
            got = ciph4[k*64 +: 64];
            exp = fwd_model(lane[k]);
            checks++;
            if (got !== exp) begin
               failures++; $display("FAIL lanes4[%0d][%0d]: got %h want %h", v, k, got, exp);
            end
         end
      end
      in4_valid = 1'b0;
      step();
      checks++;
      if (count4 !== 2'd0) begin failures++; $display("FAIL lanes4_drain: got %0d want 0", count4); end
   endtask

   initial begin
      reset = 1'b1; in_d = '0; in_inv = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in4_d = '0; in4_valid = 1'b0; out4_ready = 1'b0;
      test_reset();
      test_single_bit();
      test_mode_tag();
`ifdef IP_PERM_INV_EN
      test_roundtrip();
`endif
      test_backpressure();
      test_streaming();
      test_reset_mid();
      test_lanes4();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
